// File: rtl/fp32_sub_iterative.sv
// Iterative IEEE-754 binary32 subtractor (delta = alpha - bravo), round-to-nearest-even.
// One bit of alignment or normalisation shift per cycle; valid/ready handshake on both sides.
module fp32_sub_iterative (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alpha,
  input  logic [31:0] bravo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] delta,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] a_reg, b_reg;
  logic        spec_hold;
  logic        sign_big, eff_sub;
  logic [26:0] big_sig, small_sig;
  logic [9:0]  exp_reg;
  logic [7:0]  diff_reg;
  logic [4:0]  shift_cnt;
  logic [27:0] mant;
  logic [31:0] delta_reg;

  // Operand classification (bravo's sign is flipped: we add -bravo)
  logic        sa, sb;
  logic [7:0]  ea, eb, ea_eff, eb_eff;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [26:0] sig_a, sig_b;
  logic        a_ge_b;
  logic [31:0] special_result;

  assign sa     = a_reg[31];
  assign sb     = ~b_reg[31];
  assign ea     = a_reg[30:23];
  assign eb     = b_reg[30:23];
  assign fa     = a_reg[22:0];
  assign fb     = b_reg[22:0];
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00) && (fa == 23'd0);
  assign b_zero = (eb == 8'h00) && (fb == 23'd0);
  assign special = (ea == 8'hFF) || (eb == 8'hFF) || (a_zero && b_zero);
  assign ea_eff = (ea == 8'h00) ? 8'd1 : ea;
  assign eb_eff = (eb == 8'h00) ? 8'd1 : eb;
  assign sig_a  = {(ea != 8'h00), fa, 3'b000};
  assign sig_b  = {(eb != 8'h00), fb, 3'b000};
  assign a_ge_b = {ea_eff, sig_a} >= {eb_eff, sig_b};

  always_comb begin
    special_result = 32'h7FFFFFFF;
    if (a_nan || b_nan)
      special_result = 32'h7FFFFFFF;
    else if (a_inf && b_inf)
      special_result = (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FFFFFFF;
    else if (a_inf)
      special_result = {sa, 8'hFF, 23'd0};
    else if (b_inf)
      special_result = {sb, 8'hFF, 23'd0};
    else
      special_result = {sa & sb, 31'd0};
  end

  // Alignment, add and normalisation helpers
  logic        align_stop, align_last;
  logic [27:0] sum;
  logic        norm_left;

  assign align_stop = (diff_reg == 8'd0) || (shift_cnt == 5'd26);
  assign align_last = (diff_reg == 8'd1) || (shift_cnt == 5'd25);
  assign sum = eff_sub ? ({1'b0, big_sig} - {1'b0, small_sig})
                       : ({1'b0, big_sig} + {1'b0, small_sig});
  assign norm_left = !mant[26] && (exp_reg > 10'd1);

  // Rounding: mant[26:3] = hidden+fraction, mant[2] = G, mant[1:0] = R,S
  logic        round_up;
  logic [24:0] m_rnd;
  logic [9:0]  exp_rnd;
  logic        hidden_rnd;
  logic [31:0] round_result;

  assign round_up   = mant[2] & (mant[1] | mant[0] | mant[3]);
  assign m_rnd      = {1'b0, mant[26:3]} + {24'd0, round_up};
  assign exp_rnd    = exp_reg + {9'd0, m_rnd[24]};
  assign hidden_rnd = m_rnd[24] | m_rnd[23];

  always_comb begin
    round_result = {sign_big, (hidden_rnd ? exp_rnd[7:0] : 8'h00),
                    (m_rnd[24] ? 23'd0 : m_rnd[22:0])};
    if (exp_rnd >= 10'd255)
      round_result = {sign_big, 8'hFF, 23'd0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (in_valid) state_next = UNPACK;
      // Specials dwell one extra cycle so their latency is a fixed two cycles
      UNPACK: if (special) state_next = spec_hold ? DONE : UNPACK;
              else         state_next = ALIGN;
      ALIGN:  if (align_stop || align_last) state_next = ADD;
      ADD:    state_next = (sum == 28'd0) ? DONE : NORM;
      NORM:   if (mant[27] || !norm_left) state_next = ROUND;
      ROUND:  state_next = DONE;
      DONE:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      spec_hold <= 1'b0;
      sign_big  <= 1'b0;
      eff_sub   <= 1'b0;
      big_sig   <= 27'd0;
      small_sig <= 27'd0;
      exp_reg   <= 10'd0;
      diff_reg  <= 8'd0;
      shift_cnt <= 5'd0;
      mant      <= 28'd0;
      delta_reg <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          spec_hold <= 1'b0;
          if (in_valid) begin
            a_reg <= alpha;
            b_reg <= bravo;
          end
        end
        UNPACK: begin
          if (special) begin
            spec_hold <= 1'b1;
            delta_reg <= special_result;
          end else begin
            eff_sub   <= sa ^ sb;
            shift_cnt <= 5'd0;
            if (a_ge_b) begin
              sign_big  <= sa;
              big_sig   <= sig_a;
              small_sig <= sig_b;
              exp_reg   <= {2'b00, ea_eff};
              diff_reg  <= ea_eff - eb_eff;
            end else begin
              sign_big  <= sb;
              big_sig   <= sig_b;
              small_sig <= sig_a;
              exp_reg   <= {2'b00, eb_eff};
              diff_reg  <= eb_eff - ea_eff;
            end
          end
        end
        ALIGN: begin
          if (!align_stop) begin
            small_sig <= {1'b0, small_sig[26:2], small_sig[1] | small_sig[0]};
            diff_reg  <= diff_reg - 8'd1;
            shift_cnt <= shift_cnt + 5'd1;
          end
        end
        ADD: begin
          mant <= sum;
          if (sum == 28'd0) delta_reg <= 32'd0;
        end
        NORM: begin
          if (mant[27]) begin
            mant    <= {1'b0, mant[27:2], mant[1] | mant[0]};
            exp_reg <= exp_reg + 10'd1;
          end else if (norm_left) begin
            mant    <= {mant[26:0], 1'b0};
            exp_reg <= exp_reg - 10'd1;
          end
        end
        ROUND: delta_reg <= round_result;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign delta     = delta_reg;

endmodule

// File: tb/tb_fp32_sub_iterative.sv
// Self-checking bench for fp32_sub_iterative: scoreboard of expected results and latencies.
module tb_fp32_sub_iterative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alpha = 32'd0;
  logic [31:0] bravo = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] delta;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cap_cyc = 0;

  typedef struct {
    logic [31:0] val;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  fp32_sub_iterative dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alpha(alpha), .bravo(bravo), .out_valid(out_valid), .out_ready(out_ready),
    .delta(delta), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one operand pair when the DUT is ready and push its expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] val, input int lat);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; alpha = a; bravo = b;
    @(posedge clk); #1;
    cap_cyc = cyc;
    in_valid = 1'b0; alpha = $urandom; bravo = $urandom;
    e.val = val; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for out_valid, sample delta and latency, then consume.
  task automatic get_result(output logic [31:0] got, output int lat, output bit seen);
    int n = 0;
    seen = 1'b0;
    got = 32'hx;
    lat = -1;
    while (n < 100 && !seen) begin
      if (out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    if (seen) begin
      got = delta;
      lat = cyc - cap_cyc;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || delta !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b delta=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, delta);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  // Table of operand pairs with hand-derived results; lat < 0 means latency not checked.
  task automatic test_vectors;
    logic [31:0] ta [16] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h00800000,
                            32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h3F800000,
                            32'h3FC00000, 32'h00000000, 32'h7F800000, 32'h3F800000,
                            32'h80000000, 32'h80000000, 32'h4B800000, 32'h4C800000};
    logic [31:0] tb [16] = '{32'h3F800000, 32'h3F800000, 32'h33000000, 32'h00400000,
                            32'hFF7FFFFF, 32'h7F800000, 32'h3F800000, 32'h40400000,
                            32'hC0200000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                            32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800000};
    logic [31:0] tr [16] = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h00400000,
                            32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hC0000000,
                            32'h40800000, 32'hBF800000, 32'h7F800000, 32'hFF800000,
                            32'h80000000, 32'h00000000, 32'h4B7FFFFF, 32'h4C800000};
    int          tl [16] = '{5, -1, -1, -1, -1, 2, 2, -1, -1, -1, 2, 2, 2, 2, -1, -1};
    logic [31:0] got;
    int          lat;
    bit          seen;
    exp_t        e;
    for (int i = 0; i < 16; i++) begin
      issue(ta[i], tb[i], tr[i], tl[i]);
      get_result(got, lat, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL vec%0d_timeout: no out_valid within 100 cycles, required %h", i, e.val);
      end else if (got !== e.val) begin
        errors++;
        $display("FAIL vec%0d_value: %h - %h gave %h, required %h", i, ta[i], tb[i], got, e.val);
      end else
        $display("vec%0d %h - %h = %h lat %0d", i, ta[i], tb[i], got, lat);
      if (e.lat >= 0) begin
        checks++;
        if (lat != e.lat) begin
          errors++;
          $display("FAIL vec%0d_latency: %0d cycles, required %0d", i, lat, e.lat);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    logic [31:0] held;
    exp_t e;
    issue(32'h40400000, 32'h3F800000, 32'h40000000, 5);
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    e = exp_q.pop_front();
    held = delta;
    checks++;
    if (held !== e.val) begin
      errors++;
      $display("FAIL bp_value: %h, required %h", held, e.val);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); alpha = 32'h3F800000; bravo = 32'h40400000;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || delta !== e.val) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b delta=%h, required 1 0 %h",
                 i, out_valid, in_ready, delta, e.val);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_consume: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    $display("backpressure hold result %h", held);
  endtask

  task automatic test_reset_mid_align;
    bit stray = 1'b0;
    logic [31:0] got;
    int lat;
    bit seen;
    exp_t e;
    issue(32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, -1);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_align_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || delta !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b delta=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, delta);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL post_reset_idle: out_valid or in_ready changed, required out_valid 0 in_ready 1");
    end
    issue(32'h40400000, 32'h3F800000, 32'h40000000, 5);
    get_result(got, lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || got !== e.val || lat != e.lat) begin
      errors++;
      $display("FAIL after_reset_op: delta=%h lat=%0d, required %h lat %0d", got, lat, e.val, e.lat);
    end
    $display("reset mid-align then 3.0-1.0 = %h", got);
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    int lat;
    bit seen;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(32'h41200000, 32'h40A00000, 32'h40A00000, -1);
      get_result(got, lat, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || got !== e.val) begin
        errors++;
        $display("FAIL b2b%0d: delta=%h, required %h", i, got, e.val);
      end else
        $display("b2b%0d 10.0-5.0 = %h", i, got);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_reset_mid_align;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp32_sub_iterative.md
FP32_SUB_ITERATIVE -- requirements
Module: fp32_sub_iterative

Interface
REQ-001 The block SHALL be clocked by a single clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block accepts operands; high only in IDLE.
REQ-006 alpha  input  32  IEEE-754 binary32 minuend.
REQ-007 bravo  input  32  IEEE-754 binary32 subtrahend.
REQ-008 out_valid  output  1  delta holds a completed result.
REQ-009 out_ready  input  1  consumer takes delta.
REQ-010 delta  output  32  binary32 result of alpha - bravo.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Handshake: operands SHALL be captured on a cycle with in_valid & in_ready; the result SHALL be consumed on a cycle with out_valid & out_ready.
REQ-013 FSM states SHALL be IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
REQ-014 IDLE -> UNPACK on capture; UNPACK -> DONE for special operands, else -> ALIGN.
REQ-015 UNPACK: flip bravo sign; build 27-bit significands {hidden, frac[22:0], G, R, S} with hidden = (exp != 0); denormal exponent treated as 1; swap so the larger-magnitude operand is "big"; diff = exp_big - exp_small.
REQ-016 ALIGN: shift the small significand right 1 bit per cycle; any bit shifted out of S SHALL be ORed into S; shift count SHALL be clamped at 26 (remaining bits collapse into S); exit to ADD when diff reaches 0 or the clamp is hit.
REQ-017 ADD: 28-bit add on equal effective signs, subtract (big - small) otherwise; result sign = big sign; exact zero result SHALL give +0 (0x00000000) -> DONE.
REQ-018 NORM: carry-out SHALL shift right 1 (sticky preserved) with exp+1 in one cycle; otherwise shift left 1 bit per cycle while hidden bit = 0 and exp > 1; -> ROUND.
REQ-019 ROUND: round-to-nearest-even on G, R|S; a mantissa carry SHALL increment exp; hidden = 0 after NORM encodes exp field 0 (denormal); exp >= 255 SHALL give signed infinity.
REQ-020 Specials (UNPACK -> DONE): any NaN input -> 0x7FFFFFFF; +Inf - +Inf or -Inf - -Inf -> 0x7FFFFFFF; Inf op finite -> that Inf with effective sign; both zero -> +0, except -0 - +0 -> 0x80000000.
REQ-021 Latency from capture to out_valid SHALL be 3 + align cycles + norm cycles for finite inputs (bounded by 60), and 2 for specials.
REQ-022 DONE: out_valid = 1 and delta stable until out_ready; DONE -> IDLE on consumption; in_ready SHALL be 0 outside IDLE, so no operand is accepted while a result is pending.
REQ-023 in_valid outside IDLE SHALL be ignored; alpha/bravo changes after capture SHALL not affect the result.

Reset
REQ-024 rst high SHALL immediately force IDLE, in_ready = 1, out_valid = 0, busy = 0, delta = 0x00000000, all datapath registers cleared.
REQ-025 Reset asserted in any state, including mid-ALIGN/NORM or DONE with a pending result, SHALL discard the operation; no out_valid after release until a new capture.
REQ-026 The first capture SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-027 0x40400000 - 0x3F800000 (3.0-1.0) -> delta 0x40000000; out_valid 5 cycles after capture (1 align, 1 norm).
REQ-028 0x3F800000 - 0x3F800000 -> 0x00000000; 0x3F800000 - 0x33000000 (1 - 2^-25, tie) -> 0x3F800000.
REQ-029 0x00800000 - 0x00400000 -> 0x00400000 (denormal result); 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000 (overflow).
REQ-030 0x7F800000 - 0x7F800000 -> 0x7FFFFFFF; 0x7FC00001 - 0x3F800000 -> 0x7FFFFFFF; both 2 cycles.
REQ-031 out_ready held low 5 cycles in DONE -> delta, out_valid constant, in_ready 0, in_valid pulses ignored; consumption -> IDLE next cycle.
REQ-032 rst pulsed mid-ALIGN (0x4B000000 - 0x3F800000) -> out_valid stays 0, in_ready 1 after release; next pair computes correctly.
